// File: rtl/nfc_atom_ca_sender_if.sv
// rtl/nfc_atom_ca_sender_if.sv - request and NAND PHY signal bundle for the atomic CA sender
interface nfc_atom_ca_sender_if #(
   parameter int NumberOfWays = 4
);
   logic                    iCommand;
   logic [NumberOfWays-1:0] iTargetWay;
   logic                    iCASelect;
   logic [15:0]             iNumOfData;
   logic [39:0]             iCAData;
   logic                    oReady;
   logic                    oLastStep;
   logic [NumberOfWays-1:0] oPI_CEn;
   logic                    oPI_CLE;
   logic                    oPI_ALE;
   logic                    oPI_WEn;
   logic [7:0]              oPI_DQ;
   logic                    oPI_DQOE;

   modport master (
      output iCommand, iTargetWay, iCASelect, iNumOfData, iCAData,
      input  oReady, oLastStep, oPI_CEn, oPI_CLE, oPI_ALE, oPI_WEn, oPI_DQ, oPI_DQOE
   );

   modport slave (
      input  iCommand, iTargetWay, iCASelect, iNumOfData, iCAData,
      output oReady, oLastStep, oPI_CEn, oPI_CLE, oPI_ALE, oPI_WEn, oPI_DQ, oPI_DQOE
   );
endinterface

// File: rtl/nfc_atom_ca_sender.sv
// rtl/nfc_atom_ca_sender.sv - atomic command/address sender driving CE#/CLE/ALE/WE#/DQ
module nfc_atom_ca_sender #(
   parameter int NumberOfWays  = 4,
   parameter int SetupCycles   = 2,
   parameter int WEPulseCycles = 2,
   parameter int WEHoldCycles  = 2,
   parameter int HoldCycles    = 2
) (
   input logic                iSystemClock,
   input logic                iReset,
   nfc_atom_ca_sender_if.slave bus
);
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SETUP   = 3'd1;
   localparam logic [2:0] ST_WE_LOW  = 3'd2;
   localparam logic [2:0] ST_WE_HIGH = 3'd3;
   localparam logic [2:0] ST_HOLD    = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;

   // Timer loads dwell-1 on state entry and the state exits when it reaches zero.
   localparam logic [3:0] T_SETUP = 4'(SetupCycles - 1);
   localparam logic [3:0] T_PULSE = 4'(WEPulseCycles - 1);
   localparam logic [3:0] T_WHOLD = 4'(WEHoldCycles - 1);
   localparam logic [3:0] T_HOLD  = 4'(HoldCycles - 1);

   logic [2:0]              state_q, state_d;
   logic [3:0]              timer_q, timer_d;
   logic [2:0]              cnt_q, cnt_d;
   logic [39:0]             shift_q, shift_d;
   logic [NumberOfWays-1:0] way_q, way_d;
   logic                    casel_q, casel_d;

   logic                    ready_q, ready_d;
   logic                    last_q, last_d;
   logic [NumberOfWays-1:0] cen_q, cen_d;
   logic                    cle_q, cle_d;
   logic                    ale_q, ale_d;
   logic                    wen_q, wen_d;
   logic [7:0]              dq_q, dq_d;
   logic                    dqoe_q, dqoe_d;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      way_d   = way_q;
      casel_d = casel_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.iCommand && ready_q) begin
               way_d   = bus.iTargetWay;
               casel_d = bus.iCASelect;
               shift_d = bus.iCAData;
               cnt_d   = (bus.iNumOfData > 16'd4) ? 3'd4 : bus.iNumOfData[2:0];
               timer_d = T_SETUP;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (timer_q == 4'd0) begin
               timer_d = T_PULSE;
               state_d = ST_WE_LOW;
            end else begin
               timer_d = timer_q - 4'd1;
            end
         end
         ST_WE_LOW: begin
            if (timer_q == 4'd0) begin
               timer_d = T_WHOLD;
               state_d = ST_WE_HIGH;
            end else begin
               timer_d = timer_q - 4'd1;
            end
         end
         ST_WE_HIGH: begin
            // Keep DQ one cycle past the WE# rise before presenting the next byte.
            if ((cnt_q != 3'd0) && (timer_q == T_WHOLD)) begin
               shift_d = {shift_q[31:0], 8'h00};
            end
            if (timer_q == 4'd0) begin
               if (cnt_q != 3'd0) begin
                  cnt_d   = cnt_q - 3'd1;
                  timer_d = T_PULSE;
                  state_d = ST_WE_LOW;
               end else begin
                  timer_d = T_HOLD;
                  state_d = ST_HOLD;
               end
            end else begin
               timer_d = timer_q - 4'd1;
            end
         end
         ST_HOLD: begin
            if (timer_q == 4'd0) begin
               state_d = ST_DONE;
            end else begin
               timer_d = timer_q - 4'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every pin comes straight from a flop.
   always_comb begin
      ready_d = 1'b1;
      last_d  = 1'b0;
      cen_d   = '1;
      cle_d   = 1'b0;
      ale_d   = 1'b0;
      wen_d   = 1'b1;
      dq_d    = 8'h00;
      dqoe_d  = 1'b0;
      case (state_d)
         ST_SETUP, ST_WE_LOW, ST_WE_HIGH, ST_HOLD: begin
            ready_d = 1'b0;
            cen_d   = ~way_d;
            cle_d   = casel_d;
            ale_d   = ~casel_d;
            wen_d   = (state_d != ST_WE_LOW);
            dq_d    = shift_d[39:32];
            dqoe_d  = 1'b1;
         end
         ST_DONE: begin
            ready_d = 1'b0;
            last_d  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge iSystemClock or posedge iReset) begin
      if (iReset) begin
         state_q <= ST_IDLE;
         timer_q <= 4'd0;
         cnt_q   <= 3'd0;
         shift_q <= 40'd0;
         way_q   <= '0;
         casel_q <= 1'b0;
         ready_q <= 1'b1;
         last_q  <= 1'b0;
         cen_q   <= '1;
         cle_q   <= 1'b0;
         ale_q   <= 1'b0;
         wen_q   <= 1'b1;
         dq_q    <= 8'h00;
         dqoe_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         way_q   <= way_d;
         casel_q <= casel_d;
         ready_q <= ready_d;
         last_q  <= last_d;
         cen_q   <= cen_d;
         cle_q   <= cle_d;
         ale_q   <= ale_d;
         wen_q   <= wen_d;
         dq_q    <= dq_d;
         dqoe_q  <= dqoe_d;
      end
   end

   assign bus.oReady    = ready_q;
   assign bus.oLastStep = last_q;
   assign bus.oPI_CEn   = cen_q;
   assign bus.oPI_CLE   = cle_q;
   assign bus.oPI_ALE   = ale_q;
   assign bus.oPI_WEn   = wen_q;
   assign bus.oPI_DQ    = dq_q;
   assign bus.oPI_DQOE  = dqoe_q;
endmodule

// File: tb/tb_nfc_atom_ca_sender.sv
// tb/tb_nfc_atom_ca_sender.sv - self-checking bench for nfc_atom_ca_sender
module tb_nfc_atom_ca_sender;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic       o_ready, o_last, o_cle, o_ale, o_wen, o_dqoe;
   logic [3:0] o_cen;
   logic [7:0] o_dq;

   logic [3:0]  pend_way;
   logic        pend_cs;
   logic [15:0] pend_num;
   logic [39:0] pend_data;

   nfc_atom_ca_sender_if #(.NumberOfWays(4)) bus0 ();
   nfc_atom_ca_sender_if #(.NumberOfWays(4)) bus1 ();

   nfc_atom_ca_sender #(.NumberOfWays(4), .SetupCycles(2), .WEPulseCycles(2),
                        .WEHoldCycles(2), .HoldCycles(2)) dut0 (
      .iSystemClock(clk), .iReset(rst), .bus(bus0.slave));

   nfc_atom_ca_sender #(.NumberOfWays(4), .SetupCycles(3), .WEPulseCycles(1),
                        .WEHoldCycles(4), .HoldCycles(1)) dut1 (
      .iSystemClock(clk), .iReset(rst), .bus(bus1.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int d, input logic cmd, input logic [3:0] way, input logic cs,
                        input logic [15:0] num, input logic [39:0] data);
      if (d == 0) begin
         bus0.iCommand = cmd; bus0.iTargetWay = way; bus0.iCASelect = cs;
         bus0.iNumOfData = num; bus0.iCAData = data;
      end else begin
         bus1.iCommand = cmd; bus1.iTargetWay = way; bus1.iCASelect = cs;
         bus1.iNumOfData = num; bus1.iCAData = data;
      end
   endtask

   task automatic junk(input int d);
      drive(d, 1'($urandom), 4'($urandom), 1'($urandom), 16'($urandom), {$urandom, 8'($urandom)});
   endtask

   task automatic sample(input int d);
      if (d == 0) begin
         o_ready = bus0.oReady; o_last = bus0.oLastStep; o_cen = bus0.oPI_CEn; o_cle = bus0.oPI_CLE;
         o_ale = bus0.oPI_ALE; o_wen = bus0.oPI_WEn; o_dq = bus0.oPI_DQ; o_dqoe = bus0.oPI_DQOE;
      end else begin
         o_ready = bus1.oReady; o_last = bus1.oLastStep; o_cen = bus1.oPI_CEn; o_cle = bus1.oPI_CLE;
         o_ale = bus1.oPI_ALE; o_wen = bus1.oPI_WEn; o_dq = bus1.oPI_DQ; o_dqoe = bus1.oPI_DQOE;
      end
   endtask

   task automatic chk_idle(input string tag);
      chk(tag, 64'({o_ready, o_last, o_cen, o_cle, o_ale, o_wen, o_dq, o_dqoe}),
          64'({1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0}));
   endtask

   // One burst checked against the timing rules: busy length, pulse widths, byte order, DQ stability.
   task automatic run_burst(input int d, input logic [3:0] way, input logic cs, input logic [15:0] num,
                            input logic [39:0] data, input bit b2b_in, input bit b2b_out);
      int         n, s, p, h, ho, exp_busy, busy, lowc, highc, nfall;
      logic [7:0] exp_b[$];
      logic [7:0] got[$];
      logic       pw;
      logic [7:0] pdq;
      bit         done;
      s  = (d == 0) ? 2 : 3;
      p  = (d == 0) ? 2 : 1;
      h  = (d == 0) ? 2 : 4;
      ho = (d == 0) ? 2 : 1;
      n  = (int'(num) > 4) ? 5 : int'(num) + 1;
      for (int i = 0; i < n; i++) exp_b.push_back(data[39 - 8*i -: 8]);
      exp_busy = s + n * (p + h) + ho + 1;
      @(negedge clk);
      if (!b2b_in) drive(d, 1'b1, way, cs, num, data);
      sample(d);
      chk("ready_before_start", 64'(o_ready), 64'(1));
      @(posedge clk);
      busy = 0; pw = 1'b1; pdq = 8'h00; done = 0; lowc = 0; highc = 0; nfall = 0;
      while (!done && busy < 200) begin
         @(negedge clk);
         busy++;
         sample(d);
         if (o_last) begin
            chk("busy_cycles", 64'(busy), 64'(exp_busy));
            chk("done_pins", 64'({o_ready, o_cen, o_cle, o_ale, o_wen, o_dqoe}),
                64'({1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0}));
            if (b2b_out) drive(d, 1'b1, pend_way, pend_cs, pend_num, pend_data);
            else drive(d, 1'b0, way, cs, num, data);
            done = 1;
         end else begin
            chk("burst_ctrl", 64'({o_ready, o_cen, o_cle, o_ale, o_dqoe}),
                64'({1'b0, ~way, cs, ~cs, 1'b1}));
            if (pw && !o_wen) begin
               got.push_back(o_dq);
               chk("dq_setup", 64'(o_dq), 64'(pdq));
               if (nfall > 0) chk("we_high_width", 64'(highc), 64'(h));
               nfall++;
               lowc = 0;
            end
            if (!pw && o_wen) begin
               chk("we_low_width", 64'(lowc), 64'(p));
               chk("dq_hold", 64'(o_dq), 64'(got[got.size()-1]));
               highc = 0;
            end
            if (!o_wen) lowc++; else highc++;
            pw  = o_wen;
            pdq = o_dq;
            junk(d);
         end
      end
      if (!done) chk("last_step_timeout", 64'(0), 64'(1));
      chk("byte_count", 64'(got.size()), 64'(n));
      for (int i = 0; i < n && i < got.size(); i++) chk("byte_value", 64'(got[i]), 64'(exp_b[i]));
   endtask

   initial begin
      bit saw_last;
      drive(0, 1'b0, 4'h0, 1'b0, 16'h0, 40'h0);
      drive(1, 1'b0, 4'h0, 1'b0, 16'h0, 40'h0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      sample(0); chk_idle("reset_dut0");
      sample(1); chk_idle("reset_dut1");
      rst = 1'b0;
      @(negedge clk);
      sample(0); chk_idle("idle_dut0");

      run_burst(0, 4'b0001, 1'b1, 16'd0, 40'h70_00_00_00_00, 0, 0);
      run_burst(0, 4'b0010, 1'b0, 16'd2, 40'h12_34_56_00_00, 0, 0);
      run_burst(0, 4'b0100, 1'b0, 16'h0009, 40'hA1_B2_C3_D4_E5, 0, 0);

      pend_way = 4'b1000; pend_cs = 1'b0; pend_num = 16'd1; pend_data = {$urandom, 8'($urandom)};
      run_burst(0, 4'b0011, 1'b1, 16'd0, 40'hFF_00_00_00_00, 0, 1);
      run_burst(0, pend_way, pend_cs, pend_num, pend_data, 1, 0);

      run_burst(0, 4'b0000, 1'b0, 16'd1, 40'h5A_A5_00_00_00, 0, 0);
      run_burst(1, 4'b0001, 1'b0, 16'd1, 40'hC0_FE_00_00_00, 0, 0);

      for (int k = 0; k < 8; k++) begin
         logic [15:0] num;
         num = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 5));
         run_burst(int'($urandom_range(0, 1)), 4'($urandom), 1'($urandom), num,
                   {$urandom, 8'($urandom)}, 0, 0);
      end

      @(negedge clk);
      drive(0, 1'b1, 4'b0001, 1'b0, 16'd4, 40'h11_22_33_44_55);
      @(negedge clk);
      drive(0, 1'b0, 4'b0001, 1'b0, 16'd4, 40'h11_22_33_44_55);
      repeat (5) @(negedge clk);
      #1 rst = 1'b1;
      #1 sample(0);
      chk_idle("reset_mid_burst");
      saw_last = 0;
      repeat (3) begin
         @(negedge clk);
         sample(0);
         if (o_last) saw_last = 1;
      end
      chk("no_last_in_reset", 64'(saw_last), 64'(0));
      rst = 1'b0;
      repeat (20) begin
         @(negedge clk);
         sample(0);
         if (o_last) saw_last = 1;
      end
      chk("no_last_after_reset", 64'(saw_last), 64'(0));
      chk_idle("idle_after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
